// File: rtl/scr1_imul_pkg.sv
// scr1_imul_pkg
// Shared declarations for the iterative integer multiplier:
//   - type_scr1_mul_op_e   : RISC-V M-extension multiply opcodes
//   - type_scr1_imul_fsm_e : multiplier control states
//   - imul_abs()           : conditional two's-complement magnitude
package scr1_imul_pkg;

  // Width of the imul_abs() datapath; callers sign/zero-extend into it.
  localparam int unsigned IMUL_ABS_W = 64;

  typedef enum logic [1:0] {
    SCR1_MUL_OP_MUL    = 2'd0,  // low half, sign-agnostic
    SCR1_MUL_OP_MULH   = 2'd1,  // signed x signed, high half
    SCR1_MUL_OP_MULHSU = 2'd2,  // signed x unsigned, high half
    SCR1_MUL_OP_MULHU  = 2'd3   // unsigned x unsigned, high half
  } type_scr1_mul_op_e;

  typedef enum logic [1:0] {
    SCR1_IMUL_FSM_IDLE = 2'd0,
    SCR1_IMUL_FSM_COMP = 2'd1,
    SCR1_IMUL_FSM_FIX  = 2'd2,
    SCR1_IMUL_FSM_RESP = 2'd3
  } type_scr1_imul_fsm_e;

  // Magnitude of a value that the caller has already extended to
  // IMUL_ABS_W bits (sign-extended when signed_en, zero-extended otherwise).
  // The most negative XLEN value maps to 2^(XLEN-1), which still fits in
  // the low XLEN bits of the result.
  function automatic logic [IMUL_ABS_W-1:0] imul_abs(
    input logic [IMUL_ABS_W-1:0] value,
    input logic                  signed_en
  );
    logic [IMUL_ABS_W-1:0] res;
    if (signed_en && value[IMUL_ABS_W-1]) begin
      res = ~value + IMUL_ABS_W'(1);
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/scr1_imul_pp.sv
// scr1_imul_pp
// Combinational XLEN x DIGIT_W unsigned partial-product generator. Kept as
// its own module so a technology-specific multiplier can be swapped in.
// Ports:
//   a  [XLEN-1:0]         multiplicand magnitude
//   b  [DIGIT_W-1:0]      current multiplier digit
//   pp [XLEN+DIGIT_W-1:0] a * b
module scr1_imul_pp #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic [XLEN-1:0]         a,
  input  logic [DIGIT_W-1:0]      b,
  output logic [XLEN+DIGIT_W-1:0] pp
);

  localparam int PP_W = XLEN + DIGIT_W;

  // Full-width unsigned product of the multiplicand and one digit.
  always_comb begin
    pp = PP_W'(a) * PP_W'(b);
  end

endmodule

// File: rtl/scr1_pipe_imul.sv
// scr1_pipe_imul
// Iterative sign-magnitude multiplier for MUL/MULH/MULHSU/MULHU.
// DIGIT_W multiplier bits are retired per COMP cycle, MSB digit first,
// then the sign is applied in a single FIX cycle and the selected half
// is held in RESP until the consumer takes it.
// Ports:
//   clk, rst                synchronous active-high reset
//   flush                   kill the operation in flight, back to IDLE
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op, req_a, req_b    opcode and operands, sampled at handshake
//   req_tag                 opaque tag, echoed on resp_tag
//   resp_valid/resp_ready   response handshake
//   resp_data, resp_tag     registered result and tag
//   busy                    high whenever not IDLE
module scr1_pipe_imul
  import scr1_imul_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int N     = XLEN / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * XLEN;
  localparam int PP_W  = XLEN + DIGIT_W;

  type_scr1_imul_fsm_e   state_r;
  type_scr1_mul_op_e     op_r;
  logic [TAG_W-1:0]      tag_r;
  logic                  neg_r;
  logic [XLEN-1:0]       mag_a_r;
  logic [XLEN-1:0]       mag_b_r;
  logic [ACC_W-1:0]      acc_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  resp_valid_r;
  logic [XLEN-1:0]       resp_data_r;
  logic [TAG_W-1:0]      resp_tag_r;

  type_scr1_mul_op_e     req_op_s;
  logic                  a_signed_s;
  logic                  b_signed_s;
  logic [IMUL_ABS_W-1:0] a_ext_s;
  logic [IMUL_ABS_W-1:0] b_ext_s;
  logic [XLEN-1:0]       mag_a_s;
  logic [XLEN-1:0]       mag_b_s;
  logic [PP_W-1:0]       pp_s;
  logic [ACC_W-1:0]      acc_fix_s;
  logic [XLEN-1:0]       result_s;
  logic                  req_ready_s;
  logic                  accept_s;

  // Handshake decode from registered state; flush and rst block acceptance.
  always_comb begin
    req_ready_s = (state_r == SCR1_IMUL_FSM_IDLE) && !flush && !rst;
    accept_s    = req_valid && req_ready_s;
  end

  // Per-op operand signedness; MUL takes the unsigned path because the
  // low half of the product does not depend on operand signs.
  always_comb begin
    req_op_s   = type_scr1_mul_op_e'(req_op);
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (req_op_s)
      SCR1_MUL_OP_MULH: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      SCR1_MUL_OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  // Extend operands into the helper width and take their magnitudes.
  always_comb begin
    a_ext_s             = {IMUL_ABS_W{a_signed_s & req_a[XLEN-1]}};
    a_ext_s[XLEN-1:0]   = req_a;
    b_ext_s             = {IMUL_ABS_W{b_signed_s & req_b[XLEN-1]}};
    b_ext_s[XLEN-1:0]   = req_b;
    mag_a_s             = XLEN'(imul_abs(a_ext_s, a_signed_s));
    mag_b_s             = XLEN'(imul_abs(b_ext_s, b_signed_s));
  end

  scr1_imul_pp #(
    .XLEN    (XLEN),
    .DIGIT_W (DIGIT_W)
  ) u_pp (
    .a  (mag_a_r),
    .b  (mag_b_r[XLEN-1 -: DIGIT_W]),
    .pp (pp_s)
  );

  // Sign fixup of the full product and selection of the requested half.
  always_comb begin
    if (neg_r) begin
      acc_fix_s = ~acc_r + ACC_W'(1);
    end else begin
      acc_fix_s = acc_r;
    end
    if (op_r == SCR1_MUL_OP_MUL) begin
      result_s = acc_fix_s[XLEN-1:0];
    end else begin
      result_s = acc_fix_s[ACC_W-1:XLEN];
    end
  end

  // Control FSM, datapath registers and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SCR1_IMUL_FSM_IDLE;
      op_r         <= SCR1_MUL_OP_MUL;
      tag_r        <= '0;
      neg_r        <= 1'b0;
      mag_a_r      <= '0;
      mag_b_r      <= '0;
      acc_r        <= '0;
      cnt_r        <= '0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_tag_r   <= '0;
    end else if (flush) begin
      // Any in-flight op or pending result is dropped.
      state_r      <= SCR1_IMUL_FSM_IDLE;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        SCR1_IMUL_FSM_IDLE: begin
          if (accept_s) begin
            op_r    <= req_op_s;
            tag_r   <= req_tag;
            neg_r   <= (a_signed_s & req_a[XLEN-1]) ^ (b_signed_s & req_b[XLEN-1]);
            mag_a_r <= mag_a_s;
            mag_b_r <= mag_b_s;
            acc_r   <= '0;
            cnt_r   <= '0;
            state_r <= SCR1_IMUL_FSM_COMP;
          end else begin
            state_r <= SCR1_IMUL_FSM_IDLE;
          end
        end
        SCR1_IMUL_FSM_COMP: begin
          // MSB-first digit recurrence: shift the running sum up one
          // digit and add the next partial product.
          acc_r   <= (acc_r << DIGIT_W) + ACC_W'(pp_s);
          mag_b_r <= mag_b_r << DIGIT_W;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(N - 1)) begin
            state_r <= SCR1_IMUL_FSM_FIX;
          end else begin
            state_r <= SCR1_IMUL_FSM_COMP;
          end
        end
        SCR1_IMUL_FSM_FIX: begin
          // resp_ready is deliberately ignored here.
          resp_data_r  <= result_s;
          resp_tag_r   <= tag_r;
          resp_valid_r <= 1'b1;
          state_r      <= SCR1_IMUL_FSM_RESP;
        end
        SCR1_IMUL_FSM_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= SCR1_IMUL_FSM_IDLE;
          end else begin
            state_r      <= SCR1_IMUL_FSM_RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= SCR1_IMUL_FSM_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign busy       = (state_r != SCR1_IMUL_FSM_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_tag   = resp_tag_r;

endmodule

// File: tb/tb_scr1_pipe_imul.sv
// Directed self-checking bench for scr1_pipe_imul: a default 32/4/5
// instance and a 16/8/5 instance sharing clock and reset.
module tb_scr1_pipe_imul;

  logic        clk;
  logic        rst;

  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  logic        flush_16;
  logic        req_valid_16;
  logic        req_ready_16;
  logic [1:0]  req_op_16;
  logic [15:0] req_a_16;
  logic [15:0] req_b_16;
  logic [4:0]  req_tag_16;
  logic        resp_valid_16;
  logic        resp_ready_16;
  logic [15:0] resp_data_16;
  logic [4:0]  resp_tag_16;
  logic        busy_16;

  int n_checks = 0;
  int n_pass   = 0;

  scr1_pipe_imul #(.XLEN(32), .DIGIT_W(4), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  scr1_pipe_imul #(.XLEN(16), .DIGIT_W(8), .TAG_W(5)) dut16 (
    .clk(clk), .rst(rst), .flush(flush_16),
    .req_valid(req_valid_16), .req_ready(req_ready_16), .req_op(req_op_16),
    .req_a(req_a_16), .req_b(req_b_16), .req_tag(req_tag_16),
    .resp_valid(resp_valid_16), .resp_ready(resp_ready_16),
    .resp_data(resp_data_16), .resp_tag(resp_tag_16), .busy(busy_16)
  );

  always #5 clk = ~clk;

  // Issue one request to the 32-bit unit and wait for its response.
  // lat counts the handshake cycle plus every edge until resp_valid is seen.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] data,
                       output logic [4:0] rtag, output int lat, output bit ok);
    int w;
    ok = 1'b0; lat = 0; data = '0; rtag = '0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (w < 50) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Operands must already be captured.
      req_a = ~a; req_b = ~b; req_op = ~op; req_tag = ~tag;
      lat = 1;
      for (int i = 0; i < 60; i++) begin
        if (resp_valid) begin ok = 1'b1; break; end
        @(posedge clk); #1; lat++;
      end
      data = resp_data; rtag = resp_tag;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] tag, output logic [15:0] data,
                       output logic [4:0] rtag, output int lat, output bit ok);
    int w;
    ok = 1'b0; lat = 0; data = '0; rtag = '0;
    req_op_16 = op; req_a_16 = a; req_b_16 = b; req_tag_16 = tag; req_valid_16 = 1'b1;
    w = 0;
    while (!req_ready_16 && w < 50) begin @(posedge clk); #1; w++; end
    if (w < 50) begin
      @(posedge clk); #1;
      req_valid_16 = 1'b0;
      req_a_16 = ~a; req_b_16 = ~b; req_op_16 = ~op;
      lat = 1;
      for (int i = 0; i < 60; i++) begin
        if (resp_valid_16) begin ok = 1'b1; break; end
        @(posedge clk); #1; lat++;
      end
      data = resp_data_16; rtag = resp_tag_16;
    end else begin
      req_valid_16 = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got %h exp 0", resp_data); else n_pass++;
    n_checks++; if (resp_tag !== 5'h0) $display("FAIL reset_resp_tag got %h exp 0", resp_tag); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready_in_rst got %b exp 0", req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready_after got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_mul_basic;
    logic [31:0] d; logic [4:0] t; int lat; bit ok;
    resp_ready = 1'b1;
    run32(2'd0, 32'd7, 32'd6, 5'h0B, d, t, lat, ok);
    n_checks++; if (!ok || d !== 32'h0000002A) $display("FAIL mul_7x6_data got %h (ok=%0d) exp 0000002a", d, ok); else n_pass++;
    n_checks++; if (t !== 5'h0B) $display("FAIL mul_7x6_tag got %h exp 0b", t); else n_pass++;
    n_checks++; if (lat !== 10) $display("FAIL mul_7x6_latency got %0d exp 10", lat); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL mul_7x6_pulse got %b exp 0", resp_valid); else n_pass++;
  endtask

  task automatic test_signed_ops;
    logic [1:0]  op_t [0:8];
    logic [31:0] a_t  [0:8];
    logic [31:0] b_t  [0:8];
    logic [31:0] e_t  [0:8];
    logic [31:0] d; logic [4:0] t; int lat; bit ok;
    op_t = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};
    a_t  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000003, 32'h7FFFFFFF};
    b_t  = '{32'h80000000, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'h00000003, 32'h00000003, 32'h80000000, 32'h80000000};
    e_t  = '{32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
             32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000001, 32'hC0000000};
    resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run32(op_t[i], a_t[i], b_t[i], 5'(i + 1), d, t, lat, ok);
      n_checks++;
      if (!ok || d !== e_t[i] || t !== 5'(i + 1))
        $display("FAIL signed_op_%0d got data %h tag %h ok %0d exp data %h tag %h", i, d, t, ok, e_t[i], 5'(i + 1));
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic [4:0] t; int lat; bit ok;
    resp_ready = 1'b0;
    run32(2'd3, 32'h00010000, 32'h00030000, 5'h15, d, t, lat, ok);
    n_checks++; if (!ok || d !== 32'h00000003) $display("FAIL bp_data got %h (ok=%0d) exp 00000003", d, ok); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h3 || resp_tag !== 5'h15)
        $display("FAIL bp_hold_%0d got valid %b data %h tag %h exp 1 00000003 15", i, resp_valid, resp_data, resp_tag);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp_ready_busy_%0d got ready %b busy %b exp 0 1", i, req_ready, busy);
      else n_pass++;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_not_comb got %b exp 0", req_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_valid_after_accept got %b exp 0", resp_valid); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after_accept got %b exp 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_busy_after_accept got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_flush;
    logic [31:0] d; logic [4:0] t; int lat; bit ok; bit seen;
    // Flush while a result waits in RESP.
    resp_ready = 1'b0;
    run32(2'd0, 32'd2, 32'd3, 5'h01, d, t, lat, ok);
    n_checks++; if (!ok || d !== 32'h6) $display("FAIL flush_resp_pre got %h (ok=%0d) exp 00000006", d, ok); else n_pass++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_resp_drop got valid %b busy %b exp 0 0", resp_valid, busy); else n_pass++;
    resp_ready = 1'b1;
    // Flush in the 3rd COMP cycle with a competing request.
    req_op = 2'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'h03; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = 1'b1; req_op = 2'd3; req_a = 32'd4; req_b = 32'd4; req_tag = 5'h07;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready got %b exp 0", req_ready); else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) $display("FAIL flush_idle got busy %b valid %b exp 0 0", busy, resp_valid); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (resp_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_response got activity %b exp 0", seen); else n_pass++;
    run32(2'd3, 32'd3, 32'd5, 5'h1C, d, t, lat, ok);
    n_checks++; if (!ok || d !== 32'h0 || t !== 5'h1C) $display("FAIL flush_next_op got data %h tag %h ok %0d exp 00000000 1c", d, t, ok); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid;
    logic [31:0] d; logic [4:0] t; int lat; bit ok;
    resp_ready = 1'b1;
    run32(2'd0, 32'd7, 32'd6, 5'h0B, d, t, lat, ok);
    n_checks++; if (!ok || d !== 32'h2A) $display("FAIL rst_pre got %h (ok=%0d) exp 0000002a", d, ok); else n_pass++;
    @(posedge clk); #1;
    req_op = 2'd1; req_a = 32'h12345678; req_b = 32'h9ABCDEF0; req_tag = 5'h1F; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", resp_valid); else n_pass++;
    n_checks++; if (resp_data !== 32'h0) $display("FAIL rst_mid_data got %h exp 0", resp_data); else n_pass++;
    n_checks++; if (resp_tag !== 5'h0) $display("FAIL rst_mid_tag got %h exp 0", resp_tag); else n_pass++;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b0) $display("FAIL rst_mid_busy_ready got busy %b ready %b exp 0 0", busy, req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_release_ready got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_small_cfg;
    logic [15:0] d; logic [4:0] t; int lat; bit ok;
    resp_ready_16 = 1'b1;
    run16(2'd0, 16'h1234, 16'h5678, 5'h12, d, t, lat, ok);
    n_checks++; if (!ok || d !== 16'h0060) $display("FAIL x16_mul_data got %h (ok=%0d) exp 0060", d, ok); else n_pass++;
    n_checks++; if (t !== 5'h12) $display("FAIL x16_mul_tag got %h exp 12", t); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL x16_latency got %0d exp 4", lat); else n_pass++;
    @(posedge clk); #1;
    run16(2'd3, 16'h1234, 16'h5678, 5'h13, d, t, lat, ok);
    n_checks++; if (!ok || d !== 16'h0626) $display("FAIL x16_mulhu_data got %h (ok=%0d) exp 0626", d, ok); else n_pass++;
    @(posedge clk); #1;
    run16(2'd1, 16'hFFFF, 16'h0002, 5'h14, d, t, lat, ok);
    n_checks++; if (!ok || d !== 16'hFFFF) $display("FAIL x16_mulh_data got %h (ok=%0d) exp ffff", d, ok); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; req_tag = '0; resp_ready = 1'b1;
    flush_16 = 1'b0; req_valid_16 = 1'b0; req_op_16 = 2'd0; req_a_16 = '0; req_b_16 = '0; req_tag_16 = '0;
    resp_ready_16 = 1'b1;
    test_reset;
    test_mul_basic;
    test_signed_ops;
    test_backpressure;
    test_flush;
    test_rst_mid;
    test_small_cfg;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
